// File: rtl/cpu_pkg.sv
// cpu_pkg: ALU op codes, RISC-V opcode/funct constants and control FSM types
package cpu_pkg;
   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_XOR = 3'b100;

   localparam logic [6:0] OP_R  = 7'b0110011;
   localparam logic [6:0] OP_I  = 7'b0010011;
   localparam logic [6:0] OP_LW = 7'b0000011;
   localparam logic [6:0] OP_SW = 7'b0100011;
   localparam logic [6:0] OP_BR = 7'b1100011;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   localparam logic [2:0] F3_ADD = 3'b000;
   localparam logic [2:0] F3_XOR = 3'b100;
   localparam logic [2:0] F3_OR  = 3'b110;
   localparam logic [2:0] F3_AND = 3'b111;
   localparam logic [2:0] F3_W   = 3'b010;
   localparam logic [2:0] F3_BEQ = 3'b000;
   localparam logic [2:0] F3_BNE = 3'b001;

   typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WB} state_e;
   typedef enum logic [2:0] {C_ALU, C_LW, C_SW, C_BR, C_ILL} cls_e;

   // only the fields the decoder needs are kept in the instruction register
   typedef struct packed {
      logic [6:0] f7;
      logic [2:0] f3;
      logic [6:0] op;
   } ir_t;

   function automatic logic f3_ok(input logic [2:0] f3);
      return f3 == F3_ADD || f3 == F3_AND || f3 == F3_OR || f3 == F3_XOR;
   endfunction

   function automatic logic [2:0] f3_alu(input logic [2:0] f3);
      return f3 == F3_AND ? ALU_AND : f3 == F3_OR ? ALU_OR : f3 == F3_XOR ? ALU_XOR : ALU_ADD;
   endfunction
endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: opcode/funct3/funct7 to ALU op, operand select and instruction class
module alu_decoder
   import cpu_pkg::*;
(
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic [6:0] funct7,
   output logic [2:0] alu_ctrl,
   output logic       alu_src_imm,
   output logic       illegal_dec,
   output cls_e       cls
);
   always_comb begin
      alu_ctrl = ALU_ADD;
      alu_src_imm = 1'b0;
      cls = C_ILL;
      case (opcode)
         OP_R: begin
            if (funct7 == F7_ALT && funct3 == F3_ADD) begin
               cls = C_ALU;
               alu_ctrl = ALU_SUB;
            end else if (funct7 == F7_BASE && f3_ok(funct3)) begin
               cls = C_ALU;
               alu_ctrl = f3_alu(funct3);
            end
         end
         OP_I: begin
            if (f3_ok(funct3)) begin
               cls = C_ALU;
               alu_ctrl = f3_alu(funct3);
               alu_src_imm = 1'b1;
            end
         end
         OP_LW: begin
            if (funct3 == F3_W) begin
               cls = C_LW;
               alu_src_imm = 1'b1;
            end
         end
         OP_SW: begin
            if (funct3 == F3_W) begin
               cls = C_SW;
               alu_src_imm = 1'b1;
            end
         end
         OP_BR: begin
            if (funct3 == F3_BEQ || funct3 == F3_BNE) begin
               cls = C_BR;
               alu_ctrl = ALU_SUB;
            end
         end
         default: ;
      endcase
   end

   assign illegal_dec = cls == C_ILL;
endmodule

// File: rtl/control_unit.sv
// control_unit: multi-cycle FETCH/DECODE/EXECUTE/MEM/WB sequencer for the ALU datapath
module control_unit
   import cpu_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             instr_valid,
   input  logic [31:0]      instr,
   output logic             instr_ready,
   input  logic             zero,
   input  logic             mem_ready,
   output logic [2:0]       alu_ctrl,
   output logic             alu_src_imm,
   output logic             mem_read,
   output logic             mem_write,
   output logic             reg_write,
   output logic             pc_write,
   output logic             pc_src,
   output logic             illegal,
   output logic [CNT_W-1:0] retired_cnt
);
   state_e     state;
   ir_t        ir;
   cls_e       cls;
   logic [2:0] dec_alu;
   logic       dec_imm;
   logic       dec_ill;
   logic       pc_wr_q;
   logic       unused_fields;

   assign unused_fields = ^{instr[24:15], instr[11:7]};

   alu_decoder u_dec (
      .opcode(ir.op),
      .funct3(ir.f3),
      .funct7(ir.f7),
      .alu_ctrl(dec_alu),
      .alu_src_imm(dec_imm),
      .illegal_dec(dec_ill),
      .cls(cls)
   );

   assign alu_ctrl = state == S_FETCH ? ALU_ADD : dec_alu;
   assign alu_src_imm = state != S_FETCH && dec_imm;
   // a store retires in the very cycle memory acknowledges it
   assign pc_write = pc_wr_q || (state == S_MEM && cls == C_SW && mem_ready);
   assign pc_src = state == S_EXECUTE && cls == C_BR && (zero ^ (ir.f3 == F3_BNE));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_FETCH;
         ir <= '0;
         instr_ready <= 1'b1;
         mem_read <= 1'b0;
         mem_write <= 1'b0;
         reg_write <= 1'b0;
         pc_wr_q <= 1'b0;
         illegal <= 1'b0;
         retired_cnt <= '0;
      end else begin
         reg_write <= 1'b0;
         pc_wr_q <= 1'b0;
         illegal <= 1'b0;
         if (pc_write) retired_cnt <= retired_cnt + CNT_W'(1);
         case (state)
            S_FETCH: begin
               if (instr_valid) begin
                  ir <= '{f7: instr[31:25], f3: instr[14:12], op: instr[6:0]};
                  instr_ready <= 1'b0;
                  state <= S_DECODE;
               end
            end
            S_DECODE: begin
               state <= S_EXECUTE;
               pc_wr_q <= cls == C_BR || dec_ill;
               illegal <= dec_ill;
            end
            S_EXECUTE: begin
               if (cls == C_ALU) begin
                  state <= S_WB;
                  reg_write <= 1'b1;
                  pc_wr_q <= 1'b1;
               end else if (cls == C_LW) begin
                  state <= S_MEM;
                  mem_read <= 1'b1;
               end else if (cls == C_SW) begin
                  state <= S_MEM;
                  mem_write <= 1'b1;
               end else begin
                  state <= S_FETCH;
                  instr_ready <= 1'b1;
               end
            end
            S_MEM: begin
               if (mem_ready) begin
                  mem_read <= 1'b0;
                  mem_write <= 1'b0;
                  if (cls == C_LW) begin
                     state <= S_WB;
                     reg_write <= 1'b1;
                     pc_wr_q <= 1'b1;
                  end else begin
                     state <= S_FETCH;
                     instr_ready <= 1'b1;
                  end
               end
            end
            default: begin
               state <= S_FETCH;
               instr_ready <= 1'b1;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed and randomized checks of control_unit against a cycle-schedule model
module tb_control_unit;
   localparam int CNT_W = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic instr_valid = 1'b0;
   logic [31:0] instr = '0;
   logic zero = 1'b0;
   logic mem_ready = 1'b0;
   logic instr_ready, alu_src_imm, mem_read, mem_write, reg_write, pc_write, pc_src, illegal;
   logic [2:0] alu_ctrl;
   logic [CNT_W-1:0] retired_cnt;

   int errors = 0;
   int checks = 0;
   int exp_cnt = 0;
   int nready, pw_n, pw_c, rw_n, rw_c, mr_n, mr_first, mw_n, ill_n, ill_c;
   logic src_pw, imm1, fetch_imm;
   logic [2:0] alu1, fetch_alu;
   bit hold_bad;

   control_unit #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
      .instr_ready(instr_ready), .zero(zero), .mem_ready(mem_ready),
      .alu_ctrl(alu_ctrl), .alu_src_imm(alu_src_imm), .mem_read(mem_read),
      .mem_write(mem_write), .reg_write(reg_write), .pc_write(pc_write),
      .pc_src(pc_src), .illegal(illegal), .retired_cnt(retired_cnt)
   );

   always #5 clk = ~clk;

   // class: 0 ALU, 1 LW, 2 SW, 3 branch, 4 illegal
   function automatic void model(input logic [31:0] w, output int cls, output logic [2:0] alu, output logic imm);
      logic [6:0] op, f7;
      logic [2:0] f3;
      int lop;
      op = w[6:0];
      f3 = w[14:12];
      f7 = w[31:25];
      lop = f3 == 3'd7 ? 2 : f3 == 3'd6 ? 3 : f3 == 3'd4 ? 4 : f3 == 3'd0 ? 0 : -1;
      cls = 4;
      alu = 3'd0;
      imm = 1'b0;
      if (op == 7'h33 && f7 == 7'h00 && lop >= 0) begin cls = 0; alu = 3'(lop); end
      else if (op == 7'h33 && f7 == 7'h20 && f3 == 3'd0) begin cls = 0; alu = 3'd1; end
      else if (op == 7'h13 && lop >= 0) begin cls = 0; alu = 3'(lop); imm = 1'b1; end
      else if ((op == 7'h03 || op == 7'h23) && f3 == 3'd2) begin cls = (op == 7'h03) ? 1 : 2; imm = 1'b1; end
      else if (op == 7'h63 && f3 <= 3'd1) begin cls = 3; alu = 3'd1; end
   endfunction

   // Handshakes one instruction (cycle 0) and traces every cycle until FETCH returns.
   // zero is only meaningful in cycle 2; mem_ready rises wt cycles into MEM.
   task automatic issue(input logic [31:0] w, input logic z, input int wt);
      int c;
      c = 0;
      while (!instr_ready && c < 20) begin @(negedge clk); c++; end
      if (!instr_ready) begin checks++; errors++; $display("FAIL ready_timeout: instr_ready=%b want 1", instr_ready); end
      instr = w;
      instr_valid = 1'b1;
      zero = 1'(($urandom_range(0, 1)));
      mem_ready = 1'(($urandom_range(0, 1)));
      nready = -1; pw_n = 0; pw_c = -1; rw_n = 0; rw_c = -1; mr_n = 0; mr_first = -1; mw_n = 0;
      ill_n = 0; ill_c = -1; src_pw = 1'b0; alu1 = 3'd7; imm1 = 1'b0; hold_bad = 1'b0;
      fetch_alu = 3'd7; fetch_imm = 1'b1;
      for (c = 0; c < 20; c++) begin
         if (c > 0) begin
            @(posedge clk);
            #1;
            instr_valid = 1'(($urandom_range(0, 1)));
            instr = $urandom;
            zero = (c == 2) ? z : 1'(($urandom_range(0, 1)));
            mem_ready = (c >= 3 + wt) ? 1'b1 : (c < 3) ? 1'(($urandom_range(0, 1))) : 1'b0;
            @(negedge clk);
         end
         if (pc_write) begin pw_n++; pw_c = c; src_pw = pc_src; end
         if (reg_write) begin rw_n++; rw_c = c; end
         if (mem_read) begin mr_n++; if (mr_first < 0) mr_first = c; end
         if (mem_write) mw_n++;
         if (illegal) begin ill_n++; ill_c = c; end
         if (c == 1) begin alu1 = alu_ctrl; imm1 = alu_src_imm; end
         if (c > 1 && !instr_ready && {alu_ctrl, alu_src_imm} !== {alu1, imm1}) hold_bad = 1'b1;
         if (c > 0 && instr_ready) begin
            nready = c;
            fetch_alu = alu_ctrl;
            fetch_imm = alu_src_imm;
            break;
         end
      end
      instr_valid = 1'b0;
      exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", instr_ready); end
      checks++; if ({alu_ctrl, alu_src_imm, mem_read, mem_write, reg_write, pc_write, pc_src, illegal} !== 10'd0) begin
         errors++; $display("FAIL reset_outputs: got %b want 0", {alu_ctrl, alu_src_imm, mem_read, mem_write, reg_write, pc_write, pc_src, illegal}); end
      checks++; if (retired_cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", retired_cnt); end
      rst_n = 1'b1;
      @(negedge clk);
      checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL release_ready: got %b want 1", instr_ready); end
   endtask

   task automatic test_add();
      issue(32'h00208033, 1'b0, 0);
      checks++; if (alu1 !== 3'b000) begin errors++; $display("FAIL add_alu: got %b want 000", alu1); end
      checks++; if (rw_n !== 1 || rw_c !== 3) begin errors++; $display("FAIL add_regwrite: got n=%0d c=%0d want n=1 c=3", rw_n, rw_c); end
      checks++; if (pw_n !== 1 || pw_c !== 3) begin errors++; $display("FAIL add_pcwrite: got n=%0d c=%0d want n=1 c=3", pw_n, pw_c); end
      checks++; if (nready !== 4) begin errors++; $display("FAIL add_ready: got %0d want 4", nready); end
      checks++; if (retired_cnt !== 4'd1) begin errors++; $display("FAIL add_cnt: got %0d want 1", retired_cnt); end
   endtask

   task automatic test_back_to_back();
      int first;
      issue(32'h40208033, 1'b0, 0);
      first = nready;
      checks++; if (alu1 !== 3'b001) begin errors++; $display("FAIL b2b_sub_alu: got %b want 001", alu1); end
      checks++; if (first !== 4) begin errors++; $display("FAIL b2b_gap: got %0d want 4", first); end
      issue(32'h0020F033, 1'b0, 0);
      checks++; if (alu1 !== 3'b010) begin errors++; $display("FAIL b2b_and_alu: got %b want 010", alu1); end
      checks++; if (retired_cnt !== 4'(exp_cnt)) begin errors++; $display("FAIL b2b_cnt: got %0d want %0d", retired_cnt, exp_cnt); end
   endtask

   task automatic test_lw();
      issue(32'h0000A083, 1'b0, 3);
      checks++; if (mr_n !== 4 || mr_first !== 3) begin errors++; $display("FAIL lw_memread: got n=%0d first=%0d want n=4 first=3", mr_n, mr_first); end
      checks++; if (rw_c !== 7 || pw_c !== 7) begin errors++; $display("FAIL lw_wb: got rw=%0d pw=%0d want 7", rw_c, pw_c); end
      checks++; if (nready !== 8) begin errors++; $display("FAIL lw_ready: got %0d want 8", nready); end
      checks++; if (imm1 !== 1'b1) begin errors++; $display("FAIL lw_imm: got %b want 1", imm1); end
   endtask

   task automatic test_branch();
      logic [31:0] words [2];
      words[0] = 32'h00208063;
      words[1] = 32'h00209063;
      for (int b = 0; b < 2; b++) begin
         for (int z = 0; z < 2; z++) begin
            issue(words[b], 1'(z), 0);
            checks++; if (pw_n !== 1 || pw_c !== 2) begin errors++; $display("FAIL br_pcwrite(b=%0d z=%0d): got n=%0d c=%0d want n=1 c=2", b, z, pw_n, pw_c); end
            checks++; if (src_pw !== 1'(z ^ b)) begin errors++; $display("FAIL br_src(b=%0d z=%0d): got %b want %0d", b, z, src_pw, z ^ b); end
            checks++; if (nready !== 3 || rw_n !== 0) begin errors++; $display("FAIL br_timing(b=%0d z=%0d): got ready=%0d rw=%0d want 3/0", b, z, nready, rw_n); end
         end
      end
   endtask

   task automatic test_illegal();
      logic [31:0] words [2];
      words[0] = 32'h0000007F;
      words[1] = 32'h4020F033;
      for (int k = 0; k < 2; k++) begin
         issue(words[k], 1'b1, 0);
         checks++; if (ill_n !== 1 || ill_c !== 2) begin errors++; $display("FAIL ill_pulse(%h): got n=%0d c=%0d want n=1 c=2", words[k], ill_n, ill_c); end
         checks++; if (rw_n + mr_n + mw_n !== 0) begin errors++; $display("FAIL ill_strobes(%h): got %0d want 0", words[k], rw_n + mr_n + mw_n); end
         checks++; if (pw_c !== 2 || src_pw !== 1'b0) begin errors++; $display("FAIL ill_pc(%h): got c=%0d src=%b want c=2 src=0", words[k], pw_c, src_pw); end
         checks++; if (retired_cnt !== 4'(exp_cnt)) begin errors++; $display("FAIL ill_cnt(%h): got %0d want %0d", words[k], retired_cnt, exp_cnt); end
      end
   endtask

   task automatic test_random();
      logic [2:0] f3s [4];
      logic [31:0] w;
      logic [2:0] ealu;
      logic eimm, z, esrc;
      int cls, wt, e_ready, e_pw, e_rw, e_mr, e_mw, e_ill;
      f3s[0] = 3'd0; f3s[1] = 3'd7; f3s[2] = 3'd6; f3s[3] = 3'd4;
      for (int i = 0; i < 80; i++) begin
         w = $urandom;
         case ($urandom_range(0, 6))
            0: begin w[6:0] = 7'h33; w[31:25] = 7'h00; w[14:12] = f3s[$urandom_range(0, 3)]; end
            1: begin w[6:0] = 7'h33; w[31:25] = 7'h20; w[14:12] = 3'd0; end
            2: begin w[6:0] = 7'h13; w[14:12] = f3s[$urandom_range(0, 3)]; end
            3: begin w[6:0] = 7'h03; w[14:12] = 3'd2; end
            4: begin w[6:0] = 7'h23; w[14:12] = 3'd2; end
            5: begin w[6:0] = 7'h63; w[14:12] = 3'($urandom_range(0, 1)); end
            default: ;
         endcase
         z = 1'(($urandom_range(0, 1)));
         wt = $urandom_range(0, 3);
         model(w, cls, ealu, eimm);
         e_rw = -1; e_mr = 0; e_mw = 0; e_ill = 0; esrc = 1'b0;
         if (cls == 0) begin e_pw = 3; e_rw = 3; e_ready = 4; end
         else if (cls == 1) begin e_mr = wt + 1; e_pw = 4 + wt; e_rw = e_pw; e_ready = 5 + wt; end
         else if (cls == 2) begin e_mw = wt + 1; e_pw = 3 + wt; e_ready = 4 + wt; end
         else begin e_pw = 2; e_ready = 3; e_ill = (cls == 4) ? 1 : 0; esrc = (cls == 3) ? (z ^ w[12]) : 1'b0; end
         issue(w, z, wt);
         checks++; if (nready !== e_ready) begin errors++; $display("FAIL rnd_ready(%h): got %0d want %0d", w, nready, e_ready); end
         checks++; if (pw_n !== 1 || pw_c !== e_pw) begin errors++; $display("FAIL rnd_pcwrite(%h): got n=%0d c=%0d want c=%0d", w, pw_n, pw_c, e_pw); end
         checks++; if (src_pw !== esrc) begin errors++; $display("FAIL rnd_src(%h z=%b): got %b want %b", w, z, src_pw, esrc); end
         checks++; if (rw_c !== e_rw || rw_n !== (e_rw >= 0 ? 1 : 0)) begin errors++; $display("FAIL rnd_regwrite(%h): got n=%0d c=%0d want c=%0d", w, rw_n, rw_c, e_rw); end
         checks++; if (mr_n !== e_mr || mw_n !== e_mw) begin errors++; $display("FAIL rnd_mem(%h): got r=%0d w=%0d want r=%0d w=%0d", w, mr_n, mw_n, e_mr, e_mw); end
         checks++; if (ill_n !== e_ill) begin errors++; $display("FAIL rnd_illegal(%h): got %0d want %0d", w, ill_n, e_ill); end
         if (cls != 4) begin
            checks++; if (alu1 !== ealu || imm1 !== eimm) begin errors++; $display("FAIL rnd_decode(%h): got %b/%b want %b/%b", w, alu1, imm1, ealu, eimm); end
            checks++; if (hold_bad) begin errors++; $display("FAIL rnd_hold(%h): got unstable alu_ctrl want stable", w); end
         end
         checks++; if (fetch_alu !== 3'd0 || fetch_imm !== 1'b0) begin errors++; $display("FAIL rnd_fetch_alu(%h): got %b/%b want 000/0", w, fetch_alu, fetch_imm); end
         checks++; if (retired_cnt !== 4'(exp_cnt)) begin errors++; $display("FAIL rnd_cnt(%h): got %0d want %0d", w, retired_cnt, exp_cnt); end
      end
   endtask

   task automatic test_wrap();
      while (exp_cnt != (1 << CNT_W) - 1) issue(32'h00208033, 1'b0, 0);
      checks++; if (retired_cnt !== 4'd15) begin errors++; $display("FAIL wrap_pre: got %0d want 15", retired_cnt); end
      issue(32'h00208033, 1'b0, 0);
      checks++; if (retired_cnt !== 4'd0) begin errors++; $display("FAIL wrap: got %0d want 0", retired_cnt); end
   endtask

   task automatic test_reset_mid();
      instr = 32'h0000A083;
      instr_valid = 1'b1;
      mem_ready = 1'b0;
      @(posedge clk);
      #1 instr_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (mem_read !== 1'b1) begin errors++; $display("FAIL mid_memread: got %b want 1", mem_read); end
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++; if ({mem_read, mem_write, reg_write, pc_write, illegal} !== 5'd0) begin
         errors++; $display("FAIL mid_strobes: got %b want 0", {mem_read, mem_write, reg_write, pc_write, illegal}); end
      checks++; if (instr_ready !== 1'b1 || retired_cnt !== 4'd0) begin errors++; $display("FAIL mid_state: got ready=%b cnt=%0d want 1/0", instr_ready, retired_cnt); end
      @(negedge clk);
      rst_n = 1'b1;
      exp_cnt = 0;
      @(negedge clk);
      checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL mid_release: got %b want 1", instr_ready); end
      issue(32'h00208033, 1'b0, 0);
      checks++; if (retired_cnt !== 4'd1 || nready !== 4) begin errors++; $display("FAIL mid_resume: got cnt=%0d ready=%0d want 1/4", retired_cnt, nready); end
   endtask

   initial begin
      test_reset();
      test_add();
      test_back_to_back();
      test_lw();
      test_branch();
      test_illegal();
      test_random();
      test_wrap();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
